// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared state encoding and MIPS field definitions for instruction fetch
package inst_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_HOLD  = 2'b10,
        ST_ERR   = 2'b11
    } fetch_state_e;

    localparam int OPC_MSB   = 31;
    localparam int OPC_LSB   = 26;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;
    localparam int IMM_MSB   = 15;
    localparam int IMM_LSB   = 0;
    localparam int JIDX_MSB  = 25;
    localparam int JIDX_LSB  = 0;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_ADDIU = 6'h09;

    function automatic logic [5:0] get_opc(input logic [31:0] w);
        return w[OPC_MSB:OPC_LSB];
    endfunction

    function automatic logic [5:0] get_funct(input logic [31:0] w);
        return w[FUNCT_MSB:FUNCT_LSB];
    endfunction

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_npc_calc.sv
// rtl/inst_fetch_npc_calc.sv - combinational next-PC selection (jump > taken beq > sequential)
module npc_calc
    import inst_fetch_pkg::*;
(
    input  logic [31:0]       pc_i,
    input  logic [JIDX_MSB:0] inst_i,
    input  logic              ct_branch_i,
    input  logic              ct_jump_i,
    input  logic              alu_zero_i,
    output logic [31:0]       npc_o
);

    logic [31:0] seq;
    logic [31:0] jump_tgt;
    logic [31:0] br_off;
    logic [31:0] br_tgt;
    logic [15:0] imm;
    logic [25:0] jidx;

    assign imm  = inst_i[IMM_MSB:IMM_LSB];
    assign jidx = inst_i[JIDX_MSB:JIDX_LSB];

    // Both targets are relative to the delay-slot-free sequential address.
    assign seq      = pc_i + 32'd4;
    assign jump_tgt = {seq[31:28], jidx, 2'b00};
    assign br_off   = {{14{imm[15]}}, imm, 2'b00};
    assign br_tgt   = seq + br_off;

    always_comb begin
        npc_o = seq;
        if (ct_jump_i) begin
            npc_o = jump_tgt;
        end else if (ct_branch_i && alu_zero_i) begin
            npc_o = br_tgt;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - single-issue instruction fetch unit: PC, imem handshake, decode presentation
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [5:0]  ct_inst,
    output logic [5:0]  aluct_inst,
    output logic [31:0] pc,
    input  logic        ex_done,
    input  logic        ct_branch,
    input  logic        ct_jump,
    input  logic        alu_zero,
    output logic        fetch_err
);

    localparam int               CNT_W      = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(MAX_WAIT - 1);
    localparam logic [31:0]      PC_INITIAL = word_align(RESET_PC);

    fetch_state_e     state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      inst_q, inst_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      npc;

    npc_calc u_npc_calc (
        .pc_i        (pc_q),
        .inst_i      (inst_q[JIDX_MSB:0]),
        .ct_branch_i (ct_branch),
        .ct_jump_i   (ct_jump),
        .alu_zero_i  (alu_zero),
        .npc_o       (npc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            pc_q    <= PC_INITIAL;
            inst_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                // A ready arriving in the last allowed cycle still completes the fetch.
                if (imem_ready) begin
                    inst_d  = imem_rdata;
                    cnt_d   = '0;
                    state_d = ST_HOLD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_ERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (ex_done) begin
                    pc_d    = word_align(npc);
                    state_d = ST_FETCH;
                end
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decode straight from registered state so reset removes them asynchronously.
    assign imem_req   = (state_q == ST_FETCH);
    assign imem_addr  = pc_q;
    assign inst_valid = (state_q == ST_HOLD);
    assign fetch_err  = (state_q == ST_ERR);
    assign inst       = inst_q;
    assign ct_inst    = get_opc(inst_q);
    assign aluct_inst = get_funct(inst_q);
    assign pc         = pc_q;

endmodule
